traffic_light_monitor: RTL



---
 rtl/traffic_light_monitor.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Passive checker for the traffic light controller outputs. It confirms that
// exactly one light is on, that phases follow GREEN->YELLOW->RED->GREEN, and
// that each phase lasts its programmed time within +/- pTOL_CYCLES. Errors
// are reported on sticky flags. Completed RED->GREEN cycles are counted while
// the sequence is locked.
//
// Pipeline: the lights and en are registered once (stage 1). The phase, the
// dwell counter, the FSM and the flags update from stage 1 (stage 2). Every
// output therefore reacts two clocks after an input change. err_clr is not
// pipelined and clears the flags on the next edge. A new error detected on
// the same edge wins over the clear.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           monitor enable (tie to the controller's en)
//   green_light  observed green light
//   yellow_light observed yellow light
//   red_light    observed red light
//   err_clr      synchronous clear of the sticky error flags
//   phase        decoded phase: 0 none/invalid, 1 green, 2 yellow, 3 red
//   locked       sequence tracked and duration checks active
//   err_onehot   sticky: lights not exactly one-hot while enabled
//   err_seq      sticky: illegal phase transition
//   err_dur      sticky: phase too short or too long
//   err_any      OR of the three sticky flags
//   cycle_count  completed RED->GREEN cycles while locked, saturating
module traffic_light_monitor #(
  parameter int pSECOND_CNT_VALUE = 99,
  parameter int pGREEN_INIT_VAL   = 14,
  parameter int pYELLOW_INIT_VAL  = 2,
  parameter int pRED_INIT_VAL     = 17,
  parameter int pTOL_CYCLES       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        green_light,
  input  logic        yellow_light,
  input  logic        red_light,
  input  logic        err_clr,
  output logic [1:0]  phase,
  output logic        locked,
  output logic        err_onehot,
  output logic        err_seq,
  output logic        err_dur,
  output logic        err_any,
  output logic [15:0] cycle_count
);

  // Expected dwell per phase, in clock cycles.
  localparam int SEC_CYC = pSECOND_CNT_VALUE + 1;
  localparam int E_G     = (pGREEN_INIT_VAL + 1) * SEC_CYC;
  localparam int E_Y     = (pYELLOW_INIT_VAL + 1) * SEC_CYC;
  localparam int E_R     = (pRED_INIT_VAL + 1) * SEC_CYC;
  localparam int E_GY    = (E_G > E_Y) ? E_G : E_Y;
  localparam int E_MAX   = (E_GY > E_R) ? E_GY : E_R;
  // Wide enough to hold E+TOL+1 (the overrun point) without wrapping.
  localparam int DW      = $clog2(E_MAX + pTOL_CYCLES + 2);

  localparam logic [DW-1:0] DWELL_MAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_RED    = 2'd3;

  function automatic int exp_of(input int p);
    case (p)
      1:       return E_G;
      2:       return E_Y;
      3:       return E_R;
      default: return 0;
    endcase
  endfunction

  // Acceptable exit-dwell window per phase code. Entry 0 is never used for a
  // check because a tracked phase is never PH_NONE.
  logic [DW-1:0] lo_lim [4];
  logic [DW-1:0] hi_lim [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lim
      localparam int E_PH = exp_of(gi);
      localparam int LO   = (E_PH > pTOL_CYCLES) ? E_PH - pTOL_CYCLES : 0;
      localparam int HI   = E_PH + pTOL_CYCLES;
      assign lo_lim[gi] = DW'(LO);
      assign hi_lim[gi] = DW'(HI);
    end
  endgenerate

  // Stage 1 registers.
  logic [2:0] lights_reg;    // {green, yellow, red}
  logic       en_reg;

  // Stage 2 registers.
  logic [1:0]    state_reg, state_next;
  logic [1:0]    phase_reg, phase_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic          ovr_done_reg, ovr_done_next;  // overrun already reported this phase
  logic [15:0]   cycle_count_reg, cycle_count_next;
  logic          err_onehot_reg, err_seq_reg, err_dur_reg;

  logic          set_onehot, set_seq, set_dur;
  logic [1:0]    samp_phase;
  logic          samp_valid;
  logic [1:0]    legal_next;
  logic [DW-1:0] dwell_inc;

  // Decode the stage-1 sample; anything other than a single light is invalid.
  always_comb begin
    samp_phase = PH_NONE;
    samp_valid = 1'b0;
    case (lights_reg)
      3'b100: begin samp_phase = PH_GREEN;  samp_valid = 1'b1; end
      3'b010: begin samp_phase = PH_YELLOW; samp_valid = 1'b1; end
      3'b001: begin samp_phase = PH_RED;    samp_valid = 1'b1; end
      default: begin samp_phase = PH_NONE;  samp_valid = 1'b0; end
    endcase
  end

  assign legal_next = (phase_reg == PH_RED) ? PH_GREEN : phase_reg + 2'd1;
  assign dwell_inc  = (dwell_reg == DWELL_MAX) ? dwell_reg : dwell_reg + 1'b1;

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    dwell_next       = dwell_reg;
    ovr_done_next    = ovr_done_reg;
    cycle_count_next = cycle_count_reg;
    set_onehot       = 1'b0;
    set_seq          = 1'b0;
    set_dur          = 1'b0;

    if (!en_reg) begin
      // Disabled: an aborted phase gets no duration check.
      state_next    = ST_IDLE;
      phase_next    = PH_NONE;
      dwell_next    = '0;
      ovr_done_next = 1'b0;
    end else if (!samp_valid) begin
      // The first sample after enabling is not yet an error source.
      set_onehot    = (state_reg != ST_IDLE);
      state_next    = ST_SYNC;
      phase_next    = PH_NONE;
      dwell_next    = '0;
      ovr_done_next = 1'b0;
    end else if (state_reg == ST_IDLE || phase_reg == PH_NONE) begin
      // Adopt the phase; its start time is unknown, so no duration check.
      state_next    = ST_SYNC;
      phase_next    = samp_phase;
      dwell_next    = {{(DW-1){1'b0}}, 1'b1};
      ovr_done_next = 1'b0;
    end else if (samp_phase == phase_reg) begin
      dwell_next = dwell_inc;
      // dwell passes E+TOL only once per phase because it saturates above it.
      if (state_reg == ST_TRACK && !ovr_done_reg && dwell_reg == hi_lim[phase_reg]) begin
        set_dur       = 1'b1;
        ovr_done_next = 1'b1;
      end
    end else begin
      phase_next    = samp_phase;
      dwell_next    = {{(DW-1){1'b0}}, 1'b1};
      ovr_done_next = 1'b0;
      if (samp_phase == legal_next) begin
        if (state_reg == ST_TRACK) begin
          if (!ovr_done_reg &&
              (dwell_reg < lo_lim[phase_reg] || dwell_reg > hi_lim[phase_reg]))
            set_dur = 1'b1;
          if (phase_reg == PH_RED && cycle_count_reg != 16'hFFFF)
            cycle_count_next = cycle_count_reg + 16'd1;
        end
        state_next = ST_TRACK;
      end else begin
        set_seq    = 1'b1;
        state_next = ST_SYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lights_reg      <= 3'b000;
      en_reg          <= 1'b0;
      state_reg       <= ST_IDLE;
      phase_reg       <= PH_NONE;
      dwell_reg       <= '0;
      ovr_done_reg    <= 1'b0;
      cycle_count_reg <= 16'd0;
      err_onehot_reg  <= 1'b0;
      err_seq_reg     <= 1'b0;
      err_dur_reg     <= 1'b0;
    end else begin
      lights_reg      <= {green_light, yellow_light, red_light};
      en_reg          <= en;
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      dwell_reg       <= dwell_next;
      ovr_done_reg    <= ovr_done_next;
      cycle_count_reg <= cycle_count_next;
      err_onehot_reg  <= (err_onehot_reg & ~err_clr) | set_onehot;
      err_seq_reg     <= (err_seq_reg    & ~err_clr) | set_seq;
      err_dur_reg     <= (err_dur_reg    & ~err_clr) | set_dur;
    end
  end

  assign phase       = phase_reg;
  assign locked      = (state_reg == ST_TRACK);
  assign err_onehot  = err_onehot_reg;
  assign err_seq     = err_seq_reg;
  assign err_dur     = err_dur_reg;
  assign err_any     = err_onehot_reg | err_seq_reg | err_dur_reg;
  assign cycle_count = cycle_count_reg;

endmodule
